// File: rtl/calc_op_scheduler_if.sv
// Bundle of request, execution-unit and response signals for calc_op_scheduler.
// The slave modport is the scheduler; the master modport is the port/unit side.
interface calc_op_scheduler_if;
  logic [3:0]   req_valid;
  logic [15:0]  req_cmd;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;

  logic         arith_issue;
  logic [3:0]   arith_cmd;
  logic [31:0]  arith_a;
  logic [31:0]  arith_b;
  logic [31:0]  arith_result;
  logic [1:0]   arith_resp;

  logic         shift_issue;
  logic [3:0]   shift_cmd;
  logic [31:0]  shift_a;
  logic [31:0]  shift_b;
  logic [31:0]  shift_result;
  logic [1:0]   shift_resp;

  logic [7:0]   out_resp;
  logic [127:0] out_data;

  modport slave (
    input  req_valid, req_cmd, req_a, req_b,
    input  arith_result, arith_resp, shift_result, shift_resp,
    output req_ready,
    output arith_issue, arith_cmd, arith_a, arith_b,
    output shift_issue, shift_cmd, shift_a, shift_b,
    output out_resp, out_data
  );

  modport master (
    output req_valid, req_cmd, req_a, req_b,
    output arith_result, arith_resp, shift_result, shift_resp,
    input  req_ready,
    input  arith_issue, arith_cmd, arith_a, arith_b,
    input  shift_issue, shift_cmd, shift_a, shift_b,
    input  out_resp, out_data
  );
endinterface

// File: rtl/calc_op_scheduler.sv
// Shares one add/sub unit and one shift unit between four ports: per-port command
// slots, an oldest-first queue per unit, and per-unit tag pipelines for routing results.
module calc_op_scheduler #(
  parameter int ARITH_LAT = 1,
  parameter int SHIFT_LAT = 1
) (
  input logic               c_clk,
  input logic               reset,
  calc_op_scheduler_if.slave bus
);

  localparam int NP = 4;

  logic [3:0]           ready_q, ready_d;
  logic [3:0]           cmd_q [NP];
  logic [3:0]           cmd_d [NP];
  logic [31:0]          a_q [NP];
  logic [31:0]          a_d [NP];
  logic [31:0]          b_q [NP];
  logic [31:0]          b_d [NP];
  logic [1:0]           resp_q [NP];
  logic [1:0]           resp_d [NP];
  logic [31:0]          data_q [NP];
  logic [31:0]          data_d [NP];

  // Unit 0 is arith, unit 1 is shift; each queue holds port numbers.
  logic [1:0]           fifo_q [2][4];
  logic [1:0]           fifo_d [2][4];
  logic [2:0]           cnt_q [2];
  logic [2:0]           cnt_d [2];

  logic [ARITH_LAT-1:0] atag_v_q, atag_v_d;
  logic [1:0]           atag_p_q [ARITH_LAT];
  logic [1:0]           atag_p_d [ARITH_LAT];
  logic [SHIFT_LAT-1:0] stag_v_q, stag_v_d;
  logic [1:0]           stag_p_q [SHIFT_LAT];
  logic [1:0]           stag_p_d [SHIFT_LAT];

  logic [1:0]           issue_vld;
  logic [1:0]           head_port [2];

  function automatic logic is_arith(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2);
  endfunction

  function automatic logic is_shift(input logic [3:0] c);
    return (c == 4'd5) || (c == 4'd6);
  endfunction

  assign issue_vld[0] = (cnt_q[0] != 3'd0);
  assign issue_vld[1] = (cnt_q[1] != 3'd0);
  assign head_port[0] = fifo_q[0][0];
  assign head_port[1] = fifo_q[1][0];

  // Ready is forced low while reset is held so nothing is accepted in that window.
  assign bus.req_ready   = reset ? 4'h0 : ready_q;

  assign bus.arith_issue = issue_vld[0];
  assign bus.arith_cmd   = issue_vld[0] ? cmd_q[head_port[0]] : 4'd0;
  assign bus.arith_a     = issue_vld[0] ? a_q[head_port[0]]   : 32'd0;
  assign bus.arith_b     = issue_vld[0] ? b_q[head_port[0]]   : 32'd0;
  assign bus.shift_issue = issue_vld[1];
  assign bus.shift_cmd   = issue_vld[1] ? cmd_q[head_port[1]] : 4'd0;
  assign bus.shift_a     = issue_vld[1] ? a_q[head_port[1]]   : 32'd0;
  assign bus.shift_b     = issue_vld[1] ? b_q[head_port[1]]   : 32'd0;

  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign bus.out_resp[2*g +: 2]  = resp_q[g];
    assign bus.out_data[32*g +: 32] = data_q[g];
  end

  always_comb begin
    ready_d = ready_q;
    for (int p = 0; p < NP; p++) begin
      cmd_d[p]  = cmd_q[p];
      a_d[p]    = a_q[p];
      b_d[p]    = b_q[p];
      resp_d[p] = 2'd0;
      data_d[p] = 32'd0;
    end
    for (int u = 0; u < 2; u++) begin
      cnt_d[u] = cnt_q[u];
      for (int i = 0; i < 4; i++) fifo_d[u][i] = fifo_q[u][i];
    end

    // Pop first so this cycle's pushes land behind the remaining entries.
    for (int u = 0; u < 2; u++) begin
      if (issue_vld[u]) begin
        for (int i = 0; i < 3; i++) fifo_d[u][i] = fifo_q[u][i+1];
        fifo_d[u][3] = 2'd0;
        cnt_d[u]     = cnt_q[u] - 3'd1;
      end
    end

    for (int p = 0; p < NP; p++) begin
      if (bus.req_valid[p] && bus.req_ready[p] && (bus.req_cmd[4*p +: 4] != 4'd0)) begin
        if (is_arith(bus.req_cmd[4*p +: 4]) || is_shift(bus.req_cmd[4*p +: 4])) begin
          ready_d[p] = 1'b0;
          cmd_d[p]   = bus.req_cmd[4*p +: 4];
          a_d[p]     = bus.req_a[32*p +: 32];
          b_d[p]     = bus.req_b[32*p +: 32];
          if (is_arith(bus.req_cmd[4*p +: 4])) begin
            fifo_d[0][cnt_d[0][1:0]] = 2'(p);
            cnt_d[0] = cnt_d[0] + 3'd1;
          end else begin
            fifo_d[1][cnt_d[1][1:0]] = 2'(p);
            cnt_d[1] = cnt_d[1] + 3'd1;
          end
        end else begin
          resp_d[p] = 2'd2;
          data_d[p] = 32'd0;
        end
      end
    end

    atag_v_d[0] = issue_vld[0];
    atag_p_d[0] = head_port[0];
    for (int i = 1; i < ARITH_LAT; i++) begin
      atag_v_d[i] = atag_v_q[i-1];
      atag_p_d[i] = atag_p_q[i-1];
    end
    stag_v_d[0] = issue_vld[1];
    stag_p_d[0] = head_port[1];
    for (int i = 1; i < SHIFT_LAT; i++) begin
      stag_v_d[i] = stag_v_q[i-1];
      stag_p_d[i] = stag_p_q[i-1];
    end

    // A completing port is idle otherwise, so it can take a new command right away.
    if (atag_v_q[ARITH_LAT-1]) begin
      resp_d[atag_p_q[ARITH_LAT-1]]  = bus.arith_resp;
      data_d[atag_p_q[ARITH_LAT-1]]  = bus.arith_result;
      ready_d[atag_p_q[ARITH_LAT-1]] = 1'b1;
    end
    if (stag_v_q[SHIFT_LAT-1]) begin
      resp_d[stag_p_q[SHIFT_LAT-1]]  = bus.shift_resp;
      data_d[stag_p_q[SHIFT_LAT-1]]  = bus.shift_result;
      ready_d[stag_p_q[SHIFT_LAT-1]] = 1'b1;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      ready_q  <= 4'hF;
      atag_v_q <= '0;
      stag_v_q <= '0;
      for (int u = 0; u < 2; u++) cnt_q[u] <= 3'd0;
      for (int p = 0; p < NP; p++) begin
        resp_q[p] <= 2'd0;
        data_q[p] <= 32'd0;
      end
    end else begin
      ready_q  <= ready_d;
      atag_v_q <= atag_v_d;
      stag_v_q <= stag_v_d;
      for (int u = 0; u < 2; u++) cnt_q[u] <= cnt_d[u];
      for (int p = 0; p < NP; p++) begin
        resp_q[p] <= resp_d[p];
        data_q[p] <= data_d[p];
      end
    end
    for (int p = 0; p < NP; p++) begin
      cmd_q[p] <= cmd_d[p];
      a_q[p]   <= a_d[p];
      b_q[p]   <= b_d[p];
    end
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 4; i++) fifo_q[u][i] <= fifo_d[u][i];
    for (int i = 0; i < ARITH_LAT; i++) atag_p_q[i] <= atag_p_d[i];
    for (int i = 0; i < SHIFT_LAT; i++) stag_p_q[i] <= stag_p_d[i];
  end

endmodule

// File: tb/tb_calc_op_scheduler.sv
// Directed bench for calc_op_scheduler: one instance with single-cycle units and one
// with a three-cycle arith unit, each driven by a small behavioural unit model.
module tb_calc_op_scheduler;

  logic clk;
  logic reset;
  logic force_resp3;
  int   errors;
  int   checks;

  calc_op_scheduler_if i1 ();
  calc_op_scheduler_if i3 ();

  calc_op_scheduler #(.ARITH_LAT(1), .SHIFT_LAT(1)) dut1 (
    .c_clk (clk),
    .reset (reset),
    .bus   (i1)
  );

  calc_op_scheduler #(.ARITH_LAT(3), .SHIFT_LAT(1)) dut3 (
    .c_clk (clk),
    .reset (reset),
    .bus   (i3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural execution units: results appear LAT cycles after the issue cycle.
  logic [31:0] m1a_res, m1s_res;
  logic [1:0]  m1a_rsp, m1s_rsp;
  logic [31:0] m3a_res [3];
  logic [1:0]  m3a_rsp [3];

  always @(posedge clk) begin
    m1a_res <= alu(i1.arith_cmd, i1.arith_a, i1.arith_b);
    m1a_rsp <= i1.arith_issue ? 2'd1 : 2'd0;
    m1s_res <= alu(i1.shift_cmd, i1.shift_a, i1.shift_b);
    m1s_rsp <= i1.shift_issue ? (force_resp3 ? 2'd3 : 2'd1) : 2'd0;
    m3a_res[0] <= alu(i3.arith_cmd, i3.arith_a, i3.arith_b);
    m3a_rsp[0] <= i3.arith_issue ? 2'd1 : 2'd0;
    m3a_res[1] <= m3a_res[0];
    m3a_rsp[1] <= m3a_rsp[0];
    m3a_res[2] <= m3a_res[1];
    m3a_rsp[2] <= m3a_rsp[1];
  end

  assign i1.arith_result = m1a_res;
  assign i1.arith_resp   = m1a_rsp;
  assign i1.shift_result = m1s_res;
  assign i1.shift_resp   = m1s_rsp;
  assign i3.arith_result = m3a_res[2];
  assign i3.arith_resp   = m3a_rsp[2];
  assign i3.shift_result = 32'd0;
  assign i3.shift_resp   = 2'd0;

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    int          unit;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] sub_a [4];
  logic [31:0] sub_b [4];
  logic [31:0] sub_r [4];

  task automatic applyStimulus(input bit use3, input int p, input logic [3:0] c,
                               input logic [31:0] a, input logic [31:0] b);
    if (use3) begin
      i3.req_valid[p]        = 1'b1;
      i3.req_cmd[4*p +: 4]   = c;
      i3.req_a[32*p +: 32]   = a;
      i3.req_b[32*p +: 32]   = b;
    end else begin
      i1.req_valid[p]        = 1'b1;
      i1.req_cmd[4*p +: 4]   = c;
      i1.req_a[32*p +: 32]   = a;
      i1.req_b[32*p +: 32]   = b;
    end
  endtask

  task automatic clearStimulus();
    i1.req_valid = 4'h0;
    i3.req_valid = 4'h0;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    force_resp3  = 1'b0;
    reset        = 1'b1;
    i1.req_valid = 4'h0;
    i1.req_cmd   = 16'h0;
    i1.req_a     = 128'h0;
    i1.req_b     = 128'h0;
    i3.req_valid = 4'h0;
    i3.req_cmd   = 16'h0;
    i3.req_a     = 128'h0;
    i3.req_b     = 128'h0;

    vecs[0] = '{0, 4'd1, 32'd3,          32'd5, 0, 2'd1, 32'd8};
    vecs[1] = '{1, 4'd2, 32'd10,         32'd4, 0, 2'd1, 32'd6};
    vecs[2] = '{2, 4'd5, 32'd1,          32'd4, 1, 2'd1, 32'd16};
    vecs[3] = '{3, 4'd6, 32'd256,        32'd3, 1, 2'd1, 32'd32};
    vecs[4] = '{3, 4'd7, 32'd9,          32'd9, 2, 2'd2, 32'd0};
    vecs[5] = '{0, 4'd3, 32'd1,          32'd1, 2, 2'd2, 32'd0};
    vecs[6] = '{1, 4'd2, 32'd0,          32'd1, 0, 2'd1, 32'hFFFF_FFFF};
    vecs[7] = '{2, 4'd1, 32'hFFFF_FFFF,  32'd1, 0, 2'd1, 32'd0};

    sub_a = '{32'd100, 32'd200, 32'd300, 32'd400};
    sub_b = '{32'd1,   32'd2,   32'd3,   32'd4};
    sub_r = '{32'd99,  32'd198, 32'd297, 32'd396};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready1",  128'(i1.req_ready), 128'h0);
    checkOutput("rst_ready3",  128'(i3.req_ready), 128'h0);
    checkOutput("rst_resp",    128'(i1.out_resp),  128'h0);
    checkOutput("rst_data",    i1.out_data,        128'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready1", 128'(i1.req_ready), 128'hF);
    checkOutput("post_rst_ready3", 128'(i3.req_ready), 128'hF);
    checkOutput("post_rst_issue",  128'({i1.arith_issue, i1.shift_issue}), 128'h0);

    // Single-port vectors
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      applyStimulus(1'b0, vecs[n].port, vecs[n].cmd, vecs[n].a, vecs[n].b);
      @(negedge clk);
      checkOutput("vec_ready_after_accept", 128'(i1.req_ready[vecs[n].port]),
                  (vecs[n].unit == 2) ? 128'h1 : 128'h0);
      case (vecs[n].unit)
        0: begin
          checkOutput("vec_issue_flags", 128'({i1.arith_issue, i1.shift_issue}), 128'h2);
          checkOutput("vec_arith_ops", 128'({i1.arith_cmd, i1.arith_a, i1.arith_b}),
                      128'({vecs[n].cmd, vecs[n].a, vecs[n].b}));
        end
        1: begin
          checkOutput("vec_issue_flags", 128'({i1.arith_issue, i1.shift_issue}), 128'h1);
          checkOutput("vec_shift_ops", 128'({i1.shift_cmd, i1.shift_a, i1.shift_b}),
                      128'({vecs[n].cmd, vecs[n].a, vecs[n].b}));
        end
        default: begin
          checkOutput("inv_no_issue", 128'({i1.arith_issue, i1.shift_issue}), 128'h0);
          checkOutput("inv_resp", 128'(i1.out_resp), 128'(8'(vecs[n].resp) << (2*vecs[n].port)));
          checkOutput("inv_data", i1.out_data, 128'h0);
        end
      endcase
      clearStimulus();
      if (vecs[n].unit != 2) begin
        @(negedge clk);
        checkOutput("vec_resp_early", 128'(i1.out_resp), 128'h0);
        @(negedge clk);
        checkOutput("vec_resp", 128'(i1.out_resp), 128'(8'(vecs[n].resp) << (2*vecs[n].port)));
        checkOutput("vec_data", i1.out_data, 128'(vecs[n].data) << (32*vecs[n].port));
        checkOutput("vec_ready_back", 128'(i1.req_ready), 128'hF);
      end
      @(negedge clk);
      checkOutput("vec_resp_clear", 128'(i1.out_resp), 128'h0);
      checkOutput("vec_data_clear", i1.out_data, 128'h0);
    end

    // Four ports contend for the arith unit in one cycle
    @(negedge clk);
    for (int p = 0; p < 4; p++) applyStimulus(1'b0, p, 4'd2, sub_a[p], sub_b[p]);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("all4_ready_clr", 128'(i1.req_ready), 128'h0);
        clearStimulus();
      end
      checkOutput("all4_issue", 128'({i1.arith_issue, i1.arith_a}),
                  (c < 4) ? 128'({1'b1, sub_a[c]}) : 128'h0);
      checkOutput("all4_resp", 128'(i1.out_resp),
                  (c >= 2) ? 128'(8'h1 << (2*(c-2))) : 128'h0);
      checkOutput("all4_data", i1.out_data,
                  (c >= 2) ? (128'(sub_r[c-2]) << (32*(c-2))) : 128'h0);
    end
    @(negedge clk);
    checkOutput("all4_ready_back", 128'(i1.req_ready), 128'hF);
    checkOutput("all4_resp_clear", 128'(i1.out_resp), 128'h0);

    // Port 2 lsh and port 3 add in the same cycle
    @(negedge clk);
    applyStimulus(1'b0, 1, 4'd5, 32'd3, 32'd2);
    applyStimulus(1'b0, 2, 4'd1, 32'd7, 32'd8);
    @(negedge clk);
    checkOutput("dual_issue_flags", 128'({i1.arith_issue, i1.shift_issue}), 128'h3);
    checkOutput("dual_arith_ops", 128'({i1.arith_cmd, i1.arith_a, i1.arith_b}), 128'({4'd1, 32'd7, 32'd8}));
    checkOutput("dual_shift_ops", 128'({i1.shift_cmd, i1.shift_a, i1.shift_b}), 128'({4'd5, 32'd3, 32'd2}));
    clearStimulus();
    @(negedge clk);
    checkOutput("dual_resp_early", 128'(i1.out_resp), 128'h0);
    @(negedge clk);
    checkOutput("dual_resp", 128'(i1.out_resp), 128'h14);
    checkOutput("dual_data", i1.out_data, {32'd0, 32'd15, 32'd12, 32'd0});
    @(negedge clk);
    checkOutput("dual_resp_clear", 128'(i1.out_resp), 128'h0);

    // Unit error code 3 on port 3, then back-to-back add on the response cycle
    force_resp3 = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 2, 4'd6, 32'd64, 32'd2);
    @(negedge clk);
    checkOutput("err_shift_issue", 128'({i1.shift_issue, i1.shift_cmd}), 128'({1'b1, 4'd6}));
    clearStimulus();
    @(negedge clk);
    checkOutput("err_resp_early", 128'(i1.out_resp), 128'h0);
    @(negedge clk);
    checkOutput("err_resp", 128'(i1.out_resp), 128'h30);
    checkOutput("err_data", i1.out_data, 128'(32'd16) << 64);
    checkOutput("err_ready_back", 128'(i1.req_ready[2]), 128'h1);
    applyStimulus(1'b0, 2, 4'd1, 32'd1, 32'd1);
    force_resp3 = 1'b0;
    @(negedge clk);
    checkOutput("b2b_ready_clr", 128'(i1.req_ready[2]), 128'h0);
    checkOutput("b2b_issue", 128'({i1.arith_issue, i1.arith_cmd, i1.arith_a, i1.arith_b}),
                128'({1'b1, 4'd1, 32'd1, 32'd1}));
    clearStimulus();
    @(negedge clk);
    checkOutput("b2b_resp_early", 128'(i1.out_resp), 128'h0);
    @(negedge clk);
    checkOutput("b2b_resp", 128'(i1.out_resp), 128'h10);
    checkOutput("b2b_data", i1.out_data, 128'(32'd2) << 64);

    // Reset while ops are queued and in flight in the three-cycle arith instance
    @(negedge clk);
    for (int p = 0; p < 4; p++) applyStimulus(1'b1, p, 4'd1, 32'(p + 1), 32'd10);
    @(negedge clk);
    checkOutput("lat3_first_issue", 128'({i3.arith_issue, i3.arith_a}), 128'({1'b1, 32'd1}));
    clearStimulus();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_ready", 128'(i3.req_ready), 128'h0);
    checkOutput("mid_rst_resp",  128'(i3.out_resp),  128'h0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("post_mid_rst_issue", 128'(i3.arith_issue), 128'h0);
      checkOutput("post_mid_rst_resp",  128'(i3.out_resp),    128'h0);
      checkOutput("post_mid_rst_ready", 128'(i3.req_ready),   128'hF);
    end

    // Fresh op through the three-cycle arith instance
    applyStimulus(1'b1, 0, 4'd1, 32'd4, 32'd5);
    @(negedge clk);
    checkOutput("lat3_issue", 128'({i3.arith_issue, i3.arith_cmd}), 128'({1'b1, 4'd1}));
    clearStimulus();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("lat3_resp_wait", 128'(i3.out_resp), 128'h0);
    end
    @(negedge clk);
    checkOutput("lat3_resp", 128'(i3.out_resp), 128'h1);
    checkOutput("lat3_data", i3.out_data, 128'd9);
    checkOutput("lat3_ready_back", 128'(i3.req_ready), 128'hF);
    @(negedge clk);
    checkOutput("lat3_resp_clear", 128'(i3.out_resp), 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_op_scheduler.md
Name: calc_op_scheduler

Overview:
Four-port scheduler that shares one arithmetic unit (add/sub) and one shift unit (lsh/rsh) of the calc1 datapath between four requester ports. It latches one command per port and queues it oldest-first per unit. It issues at most one op per unit per cycle, tracks in-flight tags, and routes each result and response back to the originating port. It sits between the port front-ends and the execution units.

Parameters:
ARITH_LAT, 1, cycles from arith_issue to valid arith_result/arith_resp (>=1)
SHIFT_LAT, 1, cycles from shift_issue to valid shift_result/shift_resp (>=1)

Ports:
c_clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
req_valid  in  4  bit p-1 = port p presents a command
req_cmd  in  16  port p in bits [4(p-1) +: 4]; 0 nop, 1 add, 2 sub, 5 lsh, 6 rsh
req_a  in  128  operand 1, port p in bits [32(p-1) +: 32]
req_b  in  128  operand 2, same packing
req_ready  out  4  port slot free
arith_issue  out  1  arith op launched this cycle
arith_cmd  out  4  command to arith unit
arith_a, arith_b  out  32 each  operands to arith unit
arith_result  in  32  arith result
arith_resp  in  2  arith response code
shift_issue, shift_cmd, shift_a, shift_b, shift_result, shift_resp  same as arith_* for the shift unit
out_resp  out  8  port p in bits [2(p-1) +: 2]; 0 none, 1 success, 2 invalid/overflow, 3 internal error
out_data  out  128  port p result, same packing as req_a

Behaviour:
- Reset (sampled high at an edge):
  - clears both queues, all pending slots and both tag pipelines.
  - drives out_resp = 0, out_data = 0, req_ready = 0.
  - req_ready = 4'hF from the first cycle after reset deasserts.
  - In-flight unit results are discarded; no response is emitted for them.
- Accept: at an edge with req_valid[p] & req_ready[p] and cmd != 0:
  - latch cmd, a and b; clear req_ready[p].
  - cmd 1/2: push p onto the arith queue. cmd 5/6: push onto the shift queue.
  - A request with cmd = 0 is ignored and does not clear ready.
- Invalid cmd (nonzero, not 1/2/5/6):
  - no queue entry, no unit issue.
  - out_resp[p] = 2 and out_data[p] = 0 in the cycle after accept.
- Simultaneous accepts in one cycle are pushed in ascending port order (port 1 first).
- Queues: depth 4 each. They cannot overflow because each port has at most one outstanding op.
- Issue:
  - Each cycle a non-empty queue pops its head and drives *_issue = 1 with that port's cmd/a/b.
  - Otherwise *_issue = 0 and cmd/a/b = 0.
  - An entry pushed at edge T issues no earlier than the cycle after T.
  - Arith and shift issue independently in the same cycle.
- Fairness: strict FIFO per unit. With 4 ports contending for one unit, no port waits more than 3 issue cycles behind others.
- Tag pipeline: per unit, a LAT-deep shift register of {valid, port}.
  - For an issue in cycle k, unit outputs are sampled at the end of cycle k+LAT.
  - The port then sees out_resp/out_data in cycle k+LAT+1 for exactly one cycle.
  - out_resp/out_data return to 0 afterwards.
- Unit resp codes pass through unmodified, including 3. Result data passes through unmodified.
- req_ready[p] re-asserts in the same cycle that port's response is visible, so back-to-back commands are allowed.
- Arith and shift completions for different ports in the same cycle are both delivered. The same port cannot receive both, by the one-outstanding rule.
- Reset mid-operation: reset wins over accept, issue and completion in the same cycle.

Test Plan:
1. Port1 add a=3 b=5 (ARITH_LAT=1) -> arith_issue one cycle after accept with cmd=1; unit returns 8/1 -> out_resp[1]=1, out_data[1]=8 for exactly one cycle; req_ready[1] re-asserts that same cycle.
2. All four ports issue sub in the same cycle -> arith_issue on 4 consecutive cycles in port order 1,2,3,4; responses arrive in the same order.
3. Port2 lsh and port3 add in the same cycle -> shift_issue and arith_issue both high in the same cycle; both responses delivered in the same cycle.
4. Port4 cmd=7 -> no unit issue; out_resp[4]=2, out_data[4]=0 the cycle after accept.
5. Port1 add issued, reset asserted during the latency window (ARITH_LAT=3) -> no response; req_ready=0 during reset, 4'hF after reset deasserts; queues empty.
6. Unit returns resp=3 for port3's shift -> out_resp[3]=3 with unit data passed through; port3 accepts a new add on the response cycle.
